// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter in front of one single-port synchronous memory.
// Grants at most one access per cycle, forwards the winner's command to the
// memory and routes read data back to the requesting port READ_LAT cycles
// later. Stall outputs feed the CPU hazard logic.
module mem_arbiter #(
   parameter int NUM_PORTS = 2,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int READ_LAT  = 1,
   parameter int ARB_MODE  = 0,
   parameter int MAX_WAIT  = 7
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_PORTS-1:0]          req,
   input  logic [NUM_PORTS-1:0]          we,
   input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
   input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
   output logic [NUM_PORTS-1:0]          gnt,
   output logic [NUM_PORTS-1:0]          stall,
   output logic [NUM_PORTS-1:0]          rvalid,
   output logic [DATA_W-1:0]             rdata,
   output logic                          busy,
   output logic                          mem_en,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [DATA_W-1:0]             mem_wdata,
   input  logic [DATA_W-1:0]             mem_rdata
);

   // Width of a port index; at least one bit even for the smallest config.
   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // Wait counters saturate at this value.
   localparam logic [3:0] WAIT_SAT = 4'd15;

   // Round-robin search pointer: the port that gets first look next cycle.
   logic [PTR_W-1:0] rr_ptr_q;
   logic [PTR_W-1:0] rr_ptr_d;

   // Per-port starvation counters, only meaningful in fixed-priority mode.
   logic [NUM_PORTS-1:0][3:0] wait_cnt_q;
   logic [NUM_PORTS-1:0][3:0] wait_cnt_d;

   // Read return pipeline: one valid bit and one port id per stage.
   logic [READ_LAT-1:0]            pipe_vld_q;
   logic [READ_LAT-1:0]            pipe_vld_d;
   logic [READ_LAT-1:0][PTR_W-1:0] pipe_id_q;
   logic [READ_LAT-1:0][PTR_W-1:0] pipe_id_d;

   // Arbitration result for the current cycle.
   logic             found_c;
   logic [PTR_W-1:0] gnt_idx_c;
   int               rr_idx;

   // Pick the winning port. Nothing is granted while reset is asserted so the
   // memory never sees a command during reset.
   always_comb begin
      found_c   = 1'b0;
      gnt_idx_c = '0;
      rr_idx    = 0;
      if (rst) begin
         if (ARB_MODE == 0) begin
            // Starved ports first; lowest index among them wins.
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (!found_c && req[i] && (wait_cnt_q[i] >= 4'(MAX_WAIT))) begin
                  found_c   = 1'b1;
                  gnt_idx_c = PTR_W'(i);
               end
            end
            // Otherwise plain fixed priority, lowest index wins.
            for (int i = 0; i < NUM_PORTS; i++) begin
               if (!found_c && req[i]) begin
                  found_c   = 1'b1;
                  gnt_idx_c = PTR_W'(i);
               end
            end
         end else begin
            // Walk the ports starting at the pointer, wrapping around.
            for (int k = 0; k < NUM_PORTS; k++) begin
               rr_idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
               if (!found_c && req[rr_idx]) begin
                  found_c   = 1'b1;
                  gnt_idx_c = PTR_W'(rr_idx);
               end
            end
         end
      end
   end

   // Expand the winning index into the one-hot grant and derive stalls.
   always_comb begin
      gnt = '0;
      if (found_c) begin
         gnt[gnt_idx_c] = 1'b1;
      end
      stall = rst ? (req & ~gnt) : '0;
   end

   // Forward the granted port's command to the memory; all zero when idle.
   always_comb begin
      mem_en    = found_c;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (found_c) begin
         mem_we    = we[gnt_idx_c];
         mem_addr  = addr[gnt_idx_c*ADDR_W +: ADDR_W];
         mem_wdata = wdata[gnt_idx_c*DATA_W +: DATA_W];
      end
   end

   // Starvation counters: count cycles spent requesting without a grant.
   always_comb begin
      wait_cnt_d = '0;
      if (ARB_MODE == 0) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (req[i] && !gnt[i]) begin
               wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_SAT) ? WAIT_SAT
                                                           : wait_cnt_q[i] + 4'd1;
            end
         end
      end
   end

   // Advance the round-robin pointer past the port just served.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if ((ARB_MODE != 0) && found_c) begin
         if (gnt_idx_c == PTR_W'(NUM_PORTS - 1)) begin
            rr_ptr_d = '0;
         end else begin
            rr_ptr_d = gnt_idx_c + PTR_W'(1);
         end
      end
   end

   // Shift the return pipeline; a read grant enters a valid entry tagged
   // with its port, a write or idle cycle enters an empty one.
   always_comb begin
      pipe_vld_d    = '0;
      pipe_id_d     = '0;
      pipe_vld_d[0] = found_c && !we[gnt_idx_c];
      pipe_id_d[0]  = gnt_idx_c;
      for (int s = 1; s < READ_LAT; s++) begin
         pipe_vld_d[s] = pipe_vld_q[s-1];
         pipe_id_d[s]  = pipe_id_q[s-1];
      end
   end

   // Arbiter state registers; reset drops any reads still in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_ptr_q   <= '0;
         wait_cnt_q <= '0;
         pipe_vld_q <= '0;
         pipe_id_q  <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         wait_cnt_q <= wait_cnt_d;
         pipe_vld_q <= pipe_vld_d;
         pipe_id_q  <= pipe_id_d;
      end
   end

   // Decode the last pipeline stage into per-port rvalid and gate rdata.
   always_comb begin
      rvalid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         rvalid[i] = pipe_vld_q[READ_LAT-1] && (pipe_id_q[READ_LAT-1] == PTR_W'(i));
      end
      rdata = (|rvalid) ? mem_rdata : '0;
      busy  = |pipe_vld_q;
   end

endmodule
